// File: rtl/pcg_pkg.sv
// Shared PCG constants and XSH-RR geometry helpers.
// Used by pcg_stream and pcg_xshrr.
package pcg_pkg;

    localparam logic [63:0]  PCG_MULT_64  = 64'h5851F42D4C957F2D;
    localparam logic [63:0]  PCG_INC_64   = 64'h14057B7EF767814F;
    localparam logic [127:0] PCG_MULT_128 = 128'h2360ED051FC65DA44385DF649FCCF645;
    localparam logic [127:0] PCG_INC_128  = 128'h5851F42D4C957F2D14057B7EF767814F;

    // Number of top state bits that select the output rotation.
    function automatic int unsigned pcg_rot_bits(input int unsigned out_w);
        return $clog2(out_w);
    endfunction

    function automatic int unsigned pcg_xshift(input int unsigned out_w);
        return (pcg_rot_bits(out_w) + out_w) / 2;
    endfunction

endpackage

// File: rtl/pcg_xshrr.sv
// Combinational XSH-RR output permutation of a PCG state word.
// Parametrised on state width and output width.
module pcg_xshrr
    import pcg_pkg::*;
#(
    parameter int unsigned STATE_W = 64,
    parameter int unsigned OUT_W   = 32
) (
    input  logic [STATE_W-1:0] state_i,
    output logic [OUT_W-1:0]   perm_o
);

    localparam int unsigned ROT_BITS = pcg_rot_bits(OUT_W);
    localparam int unsigned XSHIFT   = pcg_xshift(OUT_W);
    localparam int unsigned TSHIFT   = STATE_W - OUT_W - ROT_BITS;

    logic [ROT_BITS-1:0] rot;
    logic [OUT_W-1:0]    x;
    logic [2*OUT_W-1:0]  x_dbl;

    assign rot   = state_i[STATE_W-1 -: ROT_BITS];
    assign x     = OUT_W'(((state_i >> XSHIFT) ^ state_i) >> TSHIFT);
    // Rotate right by shifting a doubled copy; the low half holds the result.
    assign x_dbl = {x, x} >> rot;
    assign perm_o = x_dbl[OUT_W-1:0];

endmodule

// File: rtl/pcg_stream.sv
// PCG random word stream with valid/ready output handshake and reseed.
// Optional accepted-word counter enabled by defining PCG_STREAM_COUNT_EN.
module pcg_stream
    import pcg_pkg::*;
#(
    parameter int unsigned  STATE_W      = 64,
    parameter int unsigned  OUT_W        = 32,
    parameter logic [127:0] MULT         = {64'h0, PCG_MULT_64},
    parameter logic [127:0] INC          = {64'h0, PCG_INC_64},
    parameter logic [127:0] SEED_DEFAULT = '0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               seed_load,
    input  logic [STATE_W-1:0] seed_in,
    input  logic               out_ready,
    output logic               out_valid,
    output logic [OUT_W-1:0]   out_data
`ifdef PCG_STREAM_COUNT_EN
    ,
    output logic [63:0]        gen_count
`endif
);

    localparam logic [STATE_W-1:0] MULT_S = MULT[STATE_W-1:0];
    localparam logic [STATE_W-1:0] INC_S  = INC[STATE_W-1:0] | {{(STATE_W-1){1'b0}}, 1'b1};
    localparam logic [STATE_W-1:0] SEED_S = SEED_DEFAULT[STATE_W-1:0];

    logic [STATE_W-1:0] state_q, state_d;
    logic               out_valid_q, out_valid_d;
    logic [OUT_W-1:0]   out_data_q, out_data_d;
    logic [OUT_W-1:0]   perm;
    logic               adv;

    pcg_xshrr #(
        .STATE_W (STATE_W),
        .OUT_W   (OUT_W)
    ) u_xshrr (
        .state_i (state_q),
        .perm_o  (perm)
    );

    assign adv = en & ~seed_load & (~out_valid_q | out_ready);

    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        if (seed_load) begin
            state_d     = seed_in;
            out_valid_d = 1'b0;
        end else if (adv) begin
            out_data_d  = perm;
            out_valid_d = 1'b1;
            state_d     = state_q * MULT_S + INC_S;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= SEED_S;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

`ifdef PCG_STREAM_COUNT_EN
    logic [63:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (seed_load) begin
            count_d = '0;
        end else if (out_valid_q & out_ready) begin
            count_d = count_q + 64'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign gen_count = count_q;
`endif

endmodule

// File: tb/tb_pcg_stream.sv
// Directed self-checking bench for pcg_stream (64/32 and 128/64 instances)
// against a C-style PCG reference model.
module tb_pcg_stream;

    logic         clk = 1'b0;
    logic         rst;
    logic         en, seed_load, out_ready, out_valid;
    logic [63:0]  seed_in;
    logic [31:0]  out_data;
    logic         en2, sl2, rdy2, vld2;
    logic [127:0] seed2;
    logic [63:0]  data2;
`ifdef PCG_STREAM_COUNT_EN
    logic [63:0]  gc64, gc128;
`endif

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    pcg_stream dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .seed_load (seed_load),
        .seed_in   (seed_in),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data)
`ifdef PCG_STREAM_COUNT_EN
        ,
        .gen_count (gc64)
`endif
    );

    pcg_stream #(
        .STATE_W (128),
        .OUT_W   (64),
        .MULT    (128'h2360ED051FC65DA44385DF649FCCF645),
        .INC     (128'h5851F42D4C957F2D14057B7EF767814F)
    ) dut128 (
        .clk       (clk),
        .rst       (rst),
        .en        (en2),
        .seed_load (sl2),
        .seed_in   (seed2),
        .out_ready (rdy2),
        .out_valid (vld2),
        .out_data  (data2)
`ifdef PCG_STREAM_COUNT_EN
        ,
        .gen_count (gc128)
`endif
    );

    // C reference: xorshifted = ((s >> 18) ^ s) >> 27; rot = s >> 59; rotr32.
    function automatic logic [31:0] perm64(input logic [63:0] s);
        logic [31:0] xs;
        logic [4:0]  r, nr;
        xs = 32'(((s >> 18) ^ s) >> 27);
        r  = s[63:59];
        nr = -r;
        return (xs >> r) | (xs << nr);
    endfunction

    function automatic logic [63:0] perm128(input logic [127:0] s);
        logic [63:0] xs;
        logic [5:0]  r, nr;
        xs = 64'(((s >> 35) ^ s) >> 58);
        r  = s[127:122];
        nr = -r;
        return (xs >> r) | (xs << nr);
    endfunction

    function automatic logic [63:0] next64(input logic [63:0] s);
        return s * 64'h5851F42D4C957F2D + 64'h14057B7EF767814F;
    endfunction

    function automatic logic [127:0] next128(input logic [127:0] s);
        return s * 128'h2360ED051FC65DA44385DF649FCCF645
                 + 128'h5851F42D4C957F2D14057B7EF767814F;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [63:0]  m;
        logic [127:0] m2;
        logic         pv, r;
        logic [31:0]  pd;

        rst = 1'b1; en = 1'b1; seed_load = 1'b1; seed_in = 64'hDEAD; out_ready = 1'b1;
        en2 = 1'b0; sl2 = 1'b0; seed2 = '0; rdy2 = 1'b0;
        step();
        step();
        chk("reset_valid", out_valid, 1'b0);
        chk("reset_data", out_data, 32'h0);
        chk("reset_state", dut.state_q, 64'h0);

        // Reseed to 0: one cycle of load latency, then perm(0) = 0.
        rst = 1'b0; seed_in = 64'h0; seed_load = 1'b1;
        step();
        chk("load_valid", out_valid, 1'b0);
        seed_load = 1'b0;
        step();
        chk("first_valid", out_valid, 1'b1);
        chk("first_word", out_data, 32'h00000000);
        m = 64'h14057B7EF767814F;
        for (int i = 0; i < 999; i++) begin
            step();
            chk($sformatf("golden_%0d", i + 1), out_data, perm64(m));
            m = next64(m);
        end

        // Random stalls: every non-stall edge presents the next model word.
        seed_in = 64'h0123456789ABCDEF; seed_load = 1'b1; out_ready = 1'b1;
        step();
        seed_load = 1'b0;
        m = 64'h0123456789ABCDEF;
        for (int i = 0; i < 200; i++) begin
            out_ready = ($urandom_range(0, 9) >= 3);
            pv = out_valid; pd = out_data; r = out_ready;
            step();
            if (pv && !r) begin
                chk("stall_valid", out_valid, 1'b1);
                chk("stall_hold", out_data, pd);
            end else begin
                chk($sformatf("stall_word_%0d", i), out_data, perm64(m));
                m = next64(m);
            end
        end

        // Reseed during a stall drops the pending word.
        out_ready = 1'b0;
        pd = out_data;
        step();
        chk("pre_seed_hold", out_data, pd);
        seed_in = 64'hFEDCBA9876543210; seed_load = 1'b1;
        step();
        chk("seed_drop_valid", out_valid, 1'b0);
        seed_load = 1'b0; out_ready = 1'b1;
        step();
        chk("seed_first_valid", out_valid, 1'b1);
        chk("seed_first_word", out_data, perm64(64'hFEDCBA9876543210));
        m = next64(64'hFEDCBA9876543210);
        step();
        chk("seed_second_word", out_data, perm64(m));
        m = next64(m);

        // Enable low freezes state and output.
        en = 1'b0;
        pd = out_data;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("en_hold_data", out_data, pd);
            chk("en_hold_valid", out_valid, 1'b1);
            chk("en_hold_state", dut.state_q, m);
        end
        en = 1'b1;
        step();
        chk("en_resume", out_data, perm64(m));
        m = next64(m);

        // State wraps modulo 2^64.
        seed_in = 64'hFFFFFFFFFFFFFFFF; seed_load = 1'b1;
        step();
        seed_load = 1'b0;
        step();
        chk("wrap_word0", out_data, perm64(64'hFFFFFFFFFFFFFFFF));
        step();
        chk("wrap_word1", out_data, perm64(next64(64'hFFFFFFFFFFFFFFFF)));

        // Reset mid-stall discards the pending word.
        out_ready = 1'b0;
        step();
        rst = 1'b1;
        step();
        chk("rst_mid_valid", out_valid, 1'b0);
        chk("rst_mid_data", out_data, 32'h0);
        rst = 1'b0; out_ready = 1'b1;
        step();
        chk("rst_after_valid", out_valid, 1'b1);
        chk("rst_after_word", out_data, perm64(64'h0));
        step();
        chk("rst_after_word2", out_data, perm64(64'h14057B7EF767814F));

        // 128/64 instance from seed 1.
        en = 1'b0;
        en2 = 1'b1; rdy2 = 1'b1; seed2 = 128'h1; sl2 = 1'b1;
        step();
        chk("w128_load_valid", vld2, 1'b0);
        sl2 = 1'b0;
        m2 = 128'h1;
        for (int i = 0; i < 100; i++) begin
            step();
            chk($sformatf("w128_word_%0d", i), data2, perm128(m2));
            m2 = next128(m2);
        end
        step();
        chk("w128_valid", vld2, 1'b1);
`ifdef PCG_STREAM_COUNT_EN
        chk("w128_count", gc128, 64'd100);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
